alu_controller: RTL and testbench
=================================

ALU_CONTROLLER -- requirements
Module: alu_controller

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clk and rst_n.
REQ-002 clk  input  1  rising-edge clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-004 ALUctr  input  4  ALU operation code.
REQ-005 OPctr  output  3  ALU result-select code, registered.
REQ-006 SUBctr  output  1  adder performs A-B (B inverted, carry-in 1) when 1, registered.
REQ-007 OVctr  output  1  overflow detection enabled when 1, registered.
REQ-008 SIGctr  output  1  signed interpretation (signed compare / arithmetic shift) when 1, registered.
REQ-009 ill_op  output  1  illegal-code flag, registered; present only when ALU_CTRL_ILLEGAL_EN is defined.
REQ-010 Port order SHALL be OPctr, SUBctr, OVctr, SIGctr, ALUctr, clk, rst_n[, ill_op].

Function
REQ-011 Decode table (ALUctr -> OPctr SUBctr OVctr SIGctr):
- 0000 ADD -> 000 0 1 1
- 0001 ADDU -> 000 0 0 0
- 0010 SUB -> 000 1 1 1
- 0011 SUBU -> 000 1 0 0
- 0100 AND -> 001 0 0 0
- 0101 OR -> 010 0 0 0
- 0110 XOR -> 011 0 0 0
- 0111 NOR -> 100 0 0 0
- 1000 SLT -> 101 1 0 1
- 1001 SLTU -> 101 1 0 0
- 1010 SLL -> 110 0 0 0
- 1011 SRL -> 111 0 0 0
- 1100 SRA -> 111 0 0 1
- 1101, 1110, 1111 reserved -> 000 0 0 0 (ADDU-equivalent).
REQ-012 Decode SHALL be purely combinational from ALUctr; all outputs SHALL be registered, latency exactly 1 clk from ALUctr sample to output.
REQ-013 Outputs SHALL hold their value while ALUctr is stable; a new ALUctr every cycle SHALL yield a new decoded value every cycle (full throughput, no handshake).
REQ-014 ALUctr wrap 1111 -> 0000 SHALL decode without any extra state or delay.
REQ-015 X/Z on ALUctr SHALL NOT be masked in simulation; synthesis treats unlisted codes as reserved.

Reset
REQ-016 When rst_n=0 at a rising clk edge, OPctr SHALL become 000 and SUBctr, OVctr, SIGctr (and ill_op) SHALL become 0, regardless of ALUctr.
REQ-017 Reset SHALL take priority over decode; the first decoded value appears on the first rising edge with rst_n=1.
REQ-018 Reset asserted mid-stream SHALL clear outputs on that edge; no asynchronous path from rst_n to outputs.

Configuration
REQ-019 Macro ALU_CTRL_ILLEGAL_EN: when defined, port ill_op exists and is registered high (1-cycle latency) for ALUctr 1101/1110/1111, low otherwise, reset to 0; reserved codes still decode to 000 0 0 0.
REQ-020 Without ALU_CTRL_ILLEGAL_EN, ill_op port and logic SHALL be absent; all other behaviour identical.

Verification
REQ-021 rst_n=0 for 2 cycles with ALUctr=0010 -> outputs 000 0 0 0; release -> next edge 000 1 1 1.
REQ-022 Sweep ALUctr 0000..1111 one code per 20 ns period -> each output equals REQ-011 row one clk later.
REQ-023 ALUctr=1000 then 1001 -> 101 1 0 1 then 101 1 0 0 (sign bit only difference).
REQ-024 ALUctr=1100 then 1011 -> 111 0 0 1 then 111 0 0 0.
REQ-025 With ALU_CTRL_ILLEGAL_EN: ALUctr=1110 -> ill_op=1 and 000 0 0 0; next ALUctr=0101 -> ill_op=0, 010 0 0 0.
REQ-026 ALUctr=0111 streaming, rst_n pulsed low one cycle -> outputs 000 0 0 0 for that cycle, 100 0 0 0 the cycle after.

Source files
------------

// File: rtl/alu_controller.sv
// ALU control decoder: maps ALUctr to registered datapath controls with one clock of latency.
// Optional ill_op flag for reserved codes is built only when ALU_CTRL_ILLEGAL_EN is defined.
module alu_controller (
    output logic [2:0] OPctr,
    output logic       SUBctr,
    output logic       OVctr,
    output logic       SIGctr,
    input  logic [3:0] ALUctr,
    input  logic       clk,
    input  logic       rst_n
`ifdef ALU_CTRL_ILLEGAL_EN
    ,
    output logic       ill_op
`endif
);

    logic [2:0] op_next;
    logic       sub_next;
    logic       ov_next;
    logic       sig_next;
`ifdef ALU_CTRL_ILLEGAL_EN
    logic       ill_next;
`endif

    // Reserved codes are listed explicitly so the default arm only catches X/Z,
    // letting unknown opcodes propagate instead of silently decoding as ADDU.
    always_comb begin
        op_next  = 3'b000;
        sub_next = 1'b0;
        ov_next  = 1'b0;
        sig_next = 1'b0;
        case (ALUctr)
            4'b0000: {op_next, sub_next, ov_next, sig_next} = 6'b000_0_1_1;
            4'b0001: {op_next, sub_next, ov_next, sig_next} = 6'b000_0_0_0;
            4'b0010: {op_next, sub_next, ov_next, sig_next} = 6'b000_1_1_1;
            4'b0011: {op_next, sub_next, ov_next, sig_next} = 6'b000_1_0_0;
            4'b0100: {op_next, sub_next, ov_next, sig_next} = 6'b001_0_0_0;
            4'b0101: {op_next, sub_next, ov_next, sig_next} = 6'b010_0_0_0;
            4'b0110: {op_next, sub_next, ov_next, sig_next} = 6'b011_0_0_0;
            4'b0111: {op_next, sub_next, ov_next, sig_next} = 6'b100_0_0_0;
            4'b1000: {op_next, sub_next, ov_next, sig_next} = 6'b101_1_0_1;
            4'b1001: {op_next, sub_next, ov_next, sig_next} = 6'b101_1_0_0;
            4'b1010: {op_next, sub_next, ov_next, sig_next} = 6'b110_0_0_0;
            4'b1011: {op_next, sub_next, ov_next, sig_next} = 6'b111_0_0_0;
            4'b1100: {op_next, sub_next, ov_next, sig_next} = 6'b111_0_0_1;
            4'b1101: {op_next, sub_next, ov_next, sig_next} = 6'b000_0_0_0;
            4'b1110: {op_next, sub_next, ov_next, sig_next} = 6'b000_0_0_0;
            4'b1111: {op_next, sub_next, ov_next, sig_next} = 6'b000_0_0_0;
            default: {op_next, sub_next, ov_next, sig_next} = 6'bxxx_x_x_x;
        endcase
    end

`ifdef ALU_CTRL_ILLEGAL_EN
    always_comb begin
        ill_next = 1'b0;
        case (ALUctr)
            4'b1101, 4'b1110, 4'b1111: ill_next = 1'b1;
            4'b0000, 4'b0001, 4'b0010, 4'b0011,
            4'b0100, 4'b0101, 4'b0110, 4'b0111,
            4'b1000, 4'b1001, 4'b1010, 4'b1011,
            4'b1100:                   ill_next = 1'b0;
            default:                   ill_next = 1'bx;
        endcase
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            OPctr  <= 3'b000;
            SUBctr <= 1'b0;
            OVctr  <= 1'b0;
            SIGctr <= 1'b0;
`ifdef ALU_CTRL_ILLEGAL_EN
            ill_op <= 1'b0;
`endif
        end else begin
            OPctr  <= op_next;
            SUBctr <= sub_next;
            OVctr  <= ov_next;
            SIGctr <= sig_next;
`ifdef ALU_CTRL_ILLEGAL_EN
            ill_op <= ill_next;
`endif
        end
    end

endmodule

// File: tb/tb_alu_controller.sv
// Directed scoreboard bench for alu_controller: expected decode is queued when a code is
// driven and popped one rising edge later; covers ill_op when ALU_CTRL_ILLEGAL_EN is defined.
module tb_alu_controller;

`ifdef ALU_CTRL_ILLEGAL_EN
    localparam int W = 7;
`else
    localparam int W = 6;
`endif

    logic [2:0] OPctr;
    logic       SUBctr;
    logic       OVctr;
    logic       SIGctr;
    logic [3:0] ALUctr;
    logic       clk;
    logic       rst_n;
`ifdef ALU_CTRL_ILLEGAL_EN
    logic       ill_op;
`endif

    alu_controller dut (
        .OPctr (OPctr),
        .SUBctr(SUBctr),
        .OVctr (OVctr),
        .SIGctr(SIGctr),
        .ALUctr(ALUctr),
        .clk   (clk),
        .rst_n (rst_n)
`ifdef ALU_CTRL_ILLEGAL_EN
        ,
        .ill_op(ill_op)
`endif
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Reference decode rows {OPctr, SUBctr, OVctr, SIGctr}, indexed by ALUctr.
    logic [5:0] decodeTable [16];
    initial begin
        decodeTable[0]  = 6'b000_0_1_1;
        decodeTable[1]  = 6'b000_0_0_0;
        decodeTable[2]  = 6'b000_1_1_1;
        decodeTable[3]  = 6'b000_1_0_0;
        decodeTable[4]  = 6'b001_0_0_0;
        decodeTable[5]  = 6'b010_0_0_0;
        decodeTable[6]  = 6'b011_0_0_0;
        decodeTable[7]  = 6'b100_0_0_0;
        decodeTable[8]  = 6'b101_1_0_1;
        decodeTable[9]  = 6'b101_1_0_0;
        decodeTable[10] = 6'b110_0_0_0;
        decodeTable[11] = 6'b111_0_0_0;
        decodeTable[12] = 6'b111_0_0_1;
        decodeTable[13] = 6'b000_0_0_0;
        decodeTable[14] = 6'b000_0_0_0;
        decodeTable[15] = 6'b000_0_0_0;
    end

    logic [W-1:0] expQueue [$];
    string        tagQueue [$];
    int           testCount = 0;
    int           failCount = 0;

    function automatic logic [W-1:0] observed();
`ifdef ALU_CTRL_ILLEGAL_EN
        return {OPctr, SUBctr, OVctr, SIGctr, ill_op};
`else
        return {OPctr, SUBctr, OVctr, SIGctr};
`endif
    endfunction

    task automatic applyStimulus(input logic [3:0] code, input logic rstVal, input string tag);
        logic [W-1:0] expVal;
        @(negedge clk);
        ALUctr = code;
        rst_n  = rstVal;
`ifdef ALU_CTRL_ILLEGAL_EN
        expVal = rstVal ? {decodeTable[code], (code >= 4'd13)} : '0;
`else
        expVal = rstVal ? decodeTable[code] : '0;
`endif
        expQueue.push_back(expVal);
        tagQueue.push_back(tag);
    endtask

    task automatic checkOutput();
        logic [W-1:0] expVal;
        logic [W-1:0] obsVal;
        string        tag;
        @(posedge clk);
        #1;
        testCount++;
        obsVal = observed();
        if (expQueue.size() == 0) begin
            failCount++;
            $error("[TB] FAIL scoreboard_empty observed=%b required=pending entry", obsVal);
        end else begin
            expVal = expQueue.pop_front();
            tag    = tagQueue.pop_front();
            assert (obsVal === expVal) else begin
                failCount++;
                $error("[TB] FAIL %s observed=%b required=%b", tag, obsVal, expVal);
            end
        end
    endtask

    task automatic step(input logic [3:0] code, input logic rstVal, input string tag);
        applyStimulus(code, rstVal, tag);
        checkOutput();
    endtask

    initial begin
        ALUctr = 4'b0000;
        rst_n  = 1'b0;

        step(4'b0010, 1'b0, "reset_cycle0");
        step(4'b0010, 1'b0, "reset_cycle1");
        step(4'b0010, 1'b1, "release_sub");

        for (int i = 0; i < 16; i++) begin
            step(4'(i), 1'b1, $sformatf("sweep_%0d", i));
        end

        step(4'b1000, 1'b1, "slt");
        step(4'b1001, 1'b1, "sltu");
        step(4'b1100, 1'b1, "sra");
        step(4'b1011, 1'b1, "srl");

        step(4'b1111, 1'b1, "wrap_reserved");
        step(4'b0000, 1'b1, "wrap_add");

        step(4'b1110, 1'b1, "reserved_1110");
        step(4'b0101, 1'b1, "or_after_reserved");
        step(4'b0101, 1'b1, "or_hold");

        step(4'b0111, 1'b1, "nor_stream0");
        step(4'b0111, 1'b0, "nor_reset_pulse");
        step(4'b0111, 1'b1, "nor_after_pulse");

        if (expQueue.size() != 0) begin
            testCount++;
            failCount++;
            $error("[TB] FAIL scoreboard_leftover observed=%0d required=0", expQueue.size());
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
